// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache with sequential line refill, flush and cancel; ports clk/rst (async active-low), IF side (inst_req, inst_addr, cancel, flush, addr_needed, inst, inst_addr_o, inst_available_out), memory side (port_calling, addr_to_mem, inst_available, inst_from_mem)
module icache_dm #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int INDEX_BITS = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic                  cancel,
  input  logic                  flush,
  output logic                  addr_needed,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_addr_o,
  output logic                  inst_available_out,
  output logic                  port_calling,
  output logic [ADDR_WIDTH-1:0] addr_to_mem,
  input  logic                  inst_available,
  input  logic [INST_WIDTH-1:0] inst_from_mem
);
  localparam int OFFSET_BITS = LINE_WORDS > 1 ? $clog2(LINE_WORDS) : 0;
  localparam int OB = OFFSET_BITS > 0 ? OFFSET_BITS : 1;
  localparam int SETS = 2 ** INDEX_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - 2 - OFFSET_BITS - INDEX_BITS;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_WORDS * 4 - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_WORDS - 1);
  localparam logic [OB-1:0] LAST = OB'(LINE_WORDS - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REFILL = 1'b1;
  logic [0:0] state;
  logic [INST_WIDTH-1:0] data [SETS][LINE_WORDS];
  logic [TAG_BITS-1:0] tags [SETS];
  logic [SETS-1:0] valid;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [OB-1:0] cnt;
  logic drop;
  logic [INST_WIDTH-1:0] rword;
  function automatic logic [OB-1:0] off_of(input logic [ADDR_WIDTH-1:0] a);
    return OB'((a >> 2) & OFF_MASK);
  endfunction
  function automatic logic [INDEX_BITS-1:0] idx_of(input logic [ADDR_WIDTH-1:0] a);
    return INDEX_BITS'(a >> (OFFSET_BITS + 2));
  endfunction
  function automatic logic [TAG_BITS-1:0] tag_of(input logic [ADDR_WIDTH-1:0] a);
    return TAG_BITS'(a >> (OFFSET_BITS + INDEX_BITS + 2));
  endfunction
  logic [INDEX_BITS-1:0] req_idx, l_idx;
  logic [OB-1:0] req_off, l_off;
  logic hit, accept, beat, last, stop;
  assign req_idx = idx_of(inst_addr);
  assign req_off = off_of(inst_addr);
  assign l_idx = idx_of(lat_addr);
  assign l_off = off_of(lat_addr);
  assign hit = valid[req_idx] && tags[req_idx] == tag_of(inst_addr);
  assign addr_needed = state == IDLE && !flush && !cancel && rst;
  assign accept = inst_req && addr_needed;
  assign beat = state == REFILL && port_calling && inst_available;
  assign last = cnt == LAST;
  // a cancel seen on the beat cycle itself ends the refill just like a latched one
  assign stop = drop || cancel || flush;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      valid <= '0;
      lat_addr <= '0;
      cnt <= '0;
      drop <= 1'b0;
      rword <= '0;
      inst <= '0;
      inst_addr_o <= '0;
      inst_available_out <= 1'b0;
      port_calling <= 1'b0;
      addr_to_mem <= '0;
    end else begin
      inst_available_out <= 1'b0;
      if (state == IDLE) begin
        if (accept && hit) begin
          inst <= data[req_idx][req_off];
          inst_addr_o <= inst_addr;
          inst_available_out <= 1'b1;
        end else if (accept) begin
          valid[req_idx] <= 1'b0;
          cnt <= '0;
          drop <= 1'b0;
          lat_addr <= inst_addr;
          addr_to_mem <= inst_addr & ~LINE_MASK;
          port_calling <= 1'b1;
          state <= REFILL;
        end
      end else begin
        if (cancel || flush) drop <= 1'b1;
        if (beat) begin
          if (cnt == l_off) rword <= inst_from_mem;
          if (stop || last) begin
            port_calling <= 1'b0;
            state <= IDLE;
            drop <= 1'b0;
          end else begin
            cnt <= cnt + OB'(1);
            addr_to_mem <= addr_to_mem + ADDR_WIDTH'(4);
          end
          if (!stop && last) begin
            valid[l_idx] <= 1'b1;
            inst <= cnt == l_off ? inst_from_mem : rword;
            inst_addr_o <= lat_addr;
            inst_available_out <= 1'b1;
          end
        end
      end
      if (flush) valid <= '0;
    end
  end
  always_ff @(posedge clk) begin
    if (beat) data[l_idx][cnt] <= inst_from_mem;
    if (beat && last) tags[l_idx] <= tag_of(lat_addr);
  end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: randomized scoreboard bench for icache_dm against a line-level cache model
module tb_icache_dm;
  logic clk = 1'b0, rst = 1'b0, inst_req = 1'b0, cancel = 1'b0, flush = 1'b0, inst_available = 1'b0;
  logic [31:0] inst_addr = '0, inst_from_mem = '0;
  logic addr_needed, inst_available_out, port_calling;
  logic [31:0] inst, inst_addr_o, addr_to_mem;
  icache_dm dut (
    .clk(clk), .rst(rst), .inst_req(inst_req), .inst_addr(inst_addr), .cancel(cancel), .flush(flush),
    .addr_needed(addr_needed), .inst(inst), .inst_addr_o(inst_addr_o), .inst_available_out(inst_available_out),
    .port_calling(port_calling), .addr_to_mem(addr_to_mem), .inst_available(inst_available), .inst_from_mem(inst_from_mem)
  );
  always #5 clk = ~clk;
  typedef struct { logic [31:0] addr; logic [31:0] data; } rsp_t;
  rsp_t exp_q[$];
  logic [31:0] beat_q[$];
  logic [31:0] mem [logic [31:0]];
  int total = 0, bad = 0, lat_max = 0;
  bit mv[16];
  logic [31:0] mt[16];
  logic [31:0] md[16][4];
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : a ^ 32'h5A5A_0000;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no progress expected completion within budget", name);
  endtask
  task automatic model_flush();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endtask
  task automatic issue(input logic [31:0] a);
    int n, idx, off;
    logic [31:0] tg, base;
    rsp_t r;
    n = 0;
    @(negedge clk);
    while (!addr_needed && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!addr_needed) begin
      timeout("accept_wait");
      return;
    end
    inst_req = 1'b1;
    inst_addr = a;
    idx = int'(a[7:4]);
    off = int'(a[3:2]);
    tg = a >> 8;
    base = a & 32'hFFFF_FFF0;
    if (!(mv[idx] && mt[idx] == tg)) begin
      for (int w = 0; w < 4; w++) begin
        beat_q.push_back(base + 32'(4 * w));
        md[idx][w] = mem_rd(base + 32'(4 * w));
      end
      mv[idx] = 1'b1;
      mt[idx] = tg;
    end
    r.addr = a;
    r.data = md[idx][off];
    exp_q.push_back(r);
    @(posedge clk);
    #1 inst_req = 1'b0;
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || port_calling || !addr_needed) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) timeout("idle_wait");
    chk("beats_done", 32'(beat_q.size()), 0);
  endtask
  task automatic wait_addr(input logic [31:0] v);
    int n;
    n = 0;
    while (!(port_calling && addr_to_mem == v) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout("addr_wait");
  endtask
  always @(negedge clk) begin
    if (rst && inst_available_out) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got inst_addr_o=%h inst=%h expected no response", inst_addr_o, inst);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_addr", inst_addr_o, e.addr);
        chk("rsp_inst", inst, e.data);
      end
    end
  end
  initial begin : responder
    logic [31:0] a;
    forever begin
      @(negedge clk);
      inst_available = 1'b0;
      if (rst && port_calling) begin
        a = addr_to_mem;
        repeat ($urandom_range(0, lat_max)) begin
          @(negedge clk);
          if (rst && port_calling) chk("addr_stable", addr_to_mem, a);
        end
        if (rst && port_calling) begin
          if (beat_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_beat: got addr_to_mem=%h expected no memory request", a);
          end else chk("beat_addr", a, beat_q.pop_front());
          inst_from_mem = mem_rd(a);
          inst_available = 1'b1;
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end
  initial begin
    #1;
    chk("rst_addr_needed", addr_needed, 0);
    chk("rst_port_calling", port_calling, 0);
    chk("rst_avail_out", inst_available_out, 0);
    chk("rst_addr_to_mem", addr_to_mem, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_addr_o", inst_addr_o, 0);
    model_flush();
    #20;
    @(negedge clk) rst = 1'b1;
    for (int w = 0; w < 4; w++) mem[32'h100 + 32'(4 * w)] = 32'hAAAA_0000 + 32'(w);
    for (int w = 0; w < 4; w++) mem[32'h500 + 32'(4 * w)] = 32'hBBBB_0000 + 32'(w);
    issue(32'h104);
    wait_idle();
    issue(32'h10C);
    @(negedge clk);
    chk("hit_pulse", inst_available_out, 1);
    chk("hit_no_mem", port_calling, 0);
    wait_idle();
    issue(32'h504);
    wait_idle();
    mem[32'h104] = 32'hCCCC_0001;
    issue(32'h104);
    wait_idle();
    @(negedge clk);
    flush = 1'b1;
    inst_req = 1'b1;
    inst_addr = 32'h104;
    #1 chk("flush_blocks", addr_needed, 0);
    @(negedge clk);
    flush = 1'b0;
    inst_req = 1'b0;
    model_flush();
    mem[32'h104] = 32'hDDDD_0001;
    issue(32'h104);
    wait_idle();
    @(negedge clk);
    cancel = 1'b1;
    inst_req = 1'b1;
    inst_addr = 32'h104;
    #1 chk("cancel_blocks", addr_needed, 0);
    @(negedge clk);
    cancel = 1'b0;
    inst_req = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk) flush = 1'b0;
    model_flush();
    issue(32'h104);
    wait_addr(32'h108);
    cancel = 1'b1;
    @(negedge clk) cancel = 1'b0;
    begin
      int n;
      n = 0;
      while (port_calling && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) timeout("cancel_drop");
    end
    repeat (3) @(negedge clk);
    chk("cancel_beats_left", 32'(beat_q.size()), 1);
    chk("cancel_no_rsp", 32'(exp_q.size()), 1);
    exp_q.delete();
    beat_q.delete();
    mv[0] = 1'b0;
    issue(32'h104);
    wait_idle();
    issue(32'h108);
    wait_idle();
    @(negedge clk) flush = 1'b1;
    @(negedge clk) flush = 1'b0;
    model_flush();
    issue(32'h104);
    wait_addr(32'h104);
    rst = 1'b0;
    #1;
    chk("midrst_port_calling", port_calling, 0);
    chk("midrst_avail_out", inst_available_out, 0);
    chk("midrst_addr_to_mem", addr_to_mem, 0);
    chk("midrst_inst", inst, 0);
    chk("midrst_inst_addr_o", inst_addr_o, 0);
    chk("midrst_addr_needed", addr_needed, 0);
    exp_q.delete();
    beat_q.delete();
    model_flush();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    issue(32'h104);
    wait_idle();
    lat_max = 5;
    for (int w = 0; w < 4; w++) mem[32'h100 + 32'(4 * w)] = $urandom;
    @(negedge clk) flush = 1'b1;
    @(negedge clk) flush = 1'b0;
    model_flush();
    issue(32'h100);
    wait_idle();
    for (int w = 0; w < 4; w++) issue(32'h100 + 32'(4 * w));
    wait_idle();
    for (int k = 0; k < 250; k++) begin
      int r;
      logic [31:0] a;
      r = int'($urandom_range(0, 19));
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
      if (r == 0) begin
        wait_idle();
        @(negedge clk) flush = 1'b1;
        @(negedge clk) flush = 1'b0;
        model_flush();
      end else if (r == 1) begin
        wait_idle();
        mem[a] = $urandom;
      end else issue(a);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("final_exp_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/icache_dm.md
# icache_dm

Parametrised direct-mapped instruction cache between the IF stage and the memory controller. It generalises the single-word fetch path to multi-word lines (`LINE_WORDS`) and a configurable number of sets (`2**INDEX_BITS`). Lines are refilled sequentially through a registered FSM. It adds valid bits, a request strobe, a whole-cache `flush` and a request `cancel`.

## Interface
- `ADDR_WIDTH`, 32, instruction address width
- `INST_WIDTH`, 32, instruction/word width
- `INDEX_BITS`, 4, set index width; sets = 2**INDEX_BITS
- `LINE_WORDS`, 4, words per line; power of two, >=1; OFFSET_BITS = log2(LINE_WORDS), 0 when LINE_WORDS=1
- `clk`  input  1  clock, rising edge
- `rst`  input  1  asynchronous, active-low reset (0 = reset)
- `inst_req`  input  1  IF request strobe
- `inst_addr`  input  ADDR_WIDTH  fetch address; bits [1:0] ignored
- `cancel`  input  1  drop current/incoming request (branch redirect)
- `flush`  input  1  invalidate entire cache (fence.i)
- `addr_needed`  output  1  cache can accept a request this cycle
- `inst`  output  INST_WIDTH  fetched instruction
- `inst_addr_o`  output  ADDR_WIDTH  address of `inst`
- `inst_available_out`  output  1  one-cycle pulse: `inst`/`inst_addr_o` valid
- `port_calling`  output  1  memory request active
- `addr_to_mem`  output  ADDR_WIDTH  word address to memory, [1:0]=0
- `inst_available`  input  1  one-cycle pulse: `inst_from_mem` valid
- `inst_from_mem`  input  INST_WIDTH  word from memory

## Operation
- Address split: offset = [OFFSET_BITS+1:2], index = next INDEX_BITS bits, tag = remaining upper bits.
- Storage: data array (sets x LINE_WORDS words), tag array, valid bit per set.
- States: IDLE, REFILL.
- `addr_needed` = (state==IDLE) && !flush && !cancel && rst. It is the only combinational output.
- Accept: rising edge with `inst_req && addr_needed`. The address is latched.
- IDLE, accept, hit (valid[index] && tag match): next cycle drive `inst_available_out`=1, `inst`=word, `inst_addr_o`=`inst_addr`. Stay in IDLE; back-to-back hits are accepted every cycle.
- IDLE, accept, miss:
  - valid[index] cleared; beat counter cnt=0.
  - Go to REFILL.
- REFILL:
  - `port_calling`=1; `addr_to_mem`={tag,index,cnt,2'b00}.
  - Each `inst_available` writes `inst_from_mem` to data[index][cnt] and increments cnt.
  - The beat at cnt==requested offset is captured as the response word.
- Last beat (cnt==LINE_WORDS-1 with `inst_available`):
  - tag written; valid[index] set; `port_calling` dropped.
  - Next cycle, `inst_available_out` pulses with the captured word and `inst_addr_o` = latched address.
  - Return to IDLE.
- `inst_available` is ignored when `port_calling`=0.
- `cancel` in REFILL: sets a drop flag. The cache waits for the in-flight beat's `inst_available`, then drops `port_calling` and returns to IDLE. The line stays invalid and no `inst_available_out` is produced.
- `cancel` with `inst_req` in IDLE: the request is not accepted. `cancel` has no effect on a hit response already registered.
- `flush`: all valid bits are cleared at the next edge. In REFILL, `flush` also acts as `cancel`. When `flush` and the last beat coincide, the line is not validated. `flush` wins over a same-cycle request.

## Timing
- Reset (`rst`=0, asynchronous):
  - `inst`, `inst_addr_o`, `inst_available_out`, `port_calling`, `addr_to_mem` = 0; `addr_needed`=0.
  - All valid bits = 0; state = IDLE; drop flag and cnt = 0.
  - A reset during REFILL abandons the transaction immediately.
- Hit latency: 1 cycle (accept edge -> `inst_available_out` high in the following cycle).
- Miss: `port_calling` rises in the cycle after accept. For a mem latency of L cycles per beat, the response arrives one cycle after the last beat, roughly 1 + LINE_WORDS*L + 1 cycles.
- Memory handshake:
  - `addr_to_mem` is held stable while `port_calling`=1 until `inst_available`.
  - It advances on the cycle after each beat; `port_calling` stays high between beats.
  - `port_calling` is low on the cycle after the final or cancelled beat.
- `inst_available_out` is never high for more than 1 cycle per accepted request. There is at most one outstanding request.

## Test plan
- Cold miss, INDEX_BITS=4, LINE_WORDS=4, req 0x104 -> `addr_to_mem` 0x100, 0x104, 0x108, 0x10C; mem returns 0xAAAA0000+n -> single pulse with `inst`=0xAAAA0001, `inst_addr_o`=0x104. Then req 0x10C -> next-cycle pulse with `inst`=0xAAAA0003 and `port_calling` stays 0.
- Conflict: after the 0x104 fill, req 0x504 (same index 0) -> refill 0x500..0x50C. Then req 0x104 misses again.
- Flush: fill 0x104, pulse `flush` for 1 cycle -> `addr_needed`=0 that cycle. Req 0x104 then refills from 0x100.
- Cancel: miss 0x104, assert `cancel` during beat 2 (addr 0x108) -> that beat completes, `port_calling` drops, no `inst_available_out`. Req 0x104 then misses.
- Reset mid-refill: drive `rst`=0 after beat 1 -> all outputs 0 immediately. After release, req 0x104 misses.
- Variable latency: `inst_available` delayed 0..5 random cycles per beat -> `addr_to_mem` stable while waiting, correct data is stored, and later hits on 0x100..0x10C return the stored words.
